// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: hex decode, leading-zero suppression, per-digit
// blanking and PWM brightness, with frame-synchronous double-buffered updates.
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int DUTY_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lzs_en,
    input  logic [DUTY_WIDTH-1:0]   brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              cathodes,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = 4 * NUM_DIGITS;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
        logic                  lzs_en;
        logic [DUTY_WIDTH-1:0] bright;
    } cfg_t;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    logic [PRESC_W-1:0]    presc_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic [DUTY_WIDTH-1:0] pwm_cnt_p0;
    cfg_t                  pend_p0;
    logic                  pend_vld_p0;
    cfg_t                  act_p0;
    cfg_t                  load_cfg;

    logic [NUM_DIGITS-1:0] anodes_p1;
    logic [6:0]            cathodes_p1;
    logic                  dp_n_p1;
    logic                  frame_done_p1;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            nib;
    logic                  all_zero;
    logic                  suppress;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] anodes_d;
    logic [6:0]            cathodes_d;
    logic                  dp_n_d;

    assign load_cfg  = '{data: digit_data, dp: dp, blank: blank, lzs_en: lzs_en, bright: brightness};
    assign slot_end  = (presc_p0 == PRESC_W'(CLK_DIV - 1));
    assign frame_end = slot_end && (idx_p0 == IDX_W'(NUM_DIGITS - 1));

    // Stage p0 -> p1: decode the current slot from the active register only
    always_comb begin
        nib        = act_p0.data[{idx_p0, 2'b00} +: 4];
        all_zero   = 1'b1;
        suppress   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (act_p0.data[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx_p0)
                suppress = act_p0.lzs_en & all_zero;
        end
        pwm_on     = (&act_p0.bright) | (pwm_cnt_p0 < act_p0.bright);
        anodes_d   = '1;
        cathodes_d = 7'h7F;
        dp_n_d     = 1'b1;
        if (!act_p0.blank[idx_p0]) begin
            cathodes_d = suppress ? 7'h7F : hex7(nib);
            dp_n_d     = ~act_p0.dp[idx_p0];
            if (pwm_on)
                anodes_d = ~(NUM_DIGITS'(1) << idx_p0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_p0      <= '0;
            idx_p0        <= '0;
            pwm_cnt_p0    <= '0;
            pend_p0       <= '0;
            pend_vld_p0   <= 1'b0;
            act_p0        <= '0;
            anodes_p1     <= '1;
            cathodes_p1   <= 7'h7F;
            dp_n_p1       <= 1'b1;
            frame_done_p1 <= 1'b0;
        end else begin
            pwm_cnt_p0 <= pwm_cnt_p0 + DUTY_WIDTH'(1);
            if (slot_end) begin
                presc_p0 <= '0;
                idx_p0   <= frame_end ? '0 : idx_p0 + IDX_W'(1);
            end else begin
                presc_p0 <= presc_p0 + PRESC_W'(1);
            end

            if (load) begin
                pend_p0     <= load_cfg;
                pend_vld_p0 <= 1'b1;
            end
            // A load on the boundary cycle itself bypasses the pending register
            if (frame_end) begin
                if (load)
                    act_p0 <= load_cfg;
                else if (pend_vld_p0)
                    act_p0 <= pend_p0;
                pend_vld_p0 <= 1'b0;
            end

            anodes_p1     <= anodes_d;
            cathodes_p1   <= cathodes_d;
            dp_n_p1       <= dp_n_d;
            frame_done_p1 <= frame_end;
        end
    end

    assign anodes     = anodes_p1;
    assign cathodes   = cathodes_p1;
    assign dp_n       = dp_n_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, CLK_DIV=4, DUTY_WIDTH=4.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs_en;
    logic [3:0]  brightness;
    logic        load;
    logic [3:0]  anodes;
    logic [6:0]  cathodes;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int low_cnt;

    logic [3:0] exp_an [4];
    logic [6:0] exp_cat[4];
    logic       exp_dpn[4];
    logic       cat_care[4];

    seven_segment_scanner #(.NUM_DIGITS(4), .CLK_DIV(4), .DUTY_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .digit_data(digit_data), .dp(dp), .blank(blank),
        .lzs_en(lzs_en), .brightness(brightness), .load(load), .anodes(anodes),
        .cathodes(cathodes), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anodes"}, 32'(anodes), 32'hF);
        check({tag, "_cathodes"}, 32'(cathodes), 32'h7F);
        check({tag, "_dp_n"}, 32'(dp_n), 32'h1);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output at cycle k shows slot ((k-1)/4)%4; frame_done follows each 16-cycle boundary
    task automatic check_cycle();
        int s;
        s = ((cyc - 1) / 4) % 4;
        check("anodes", 32'(anodes), 32'(exp_an[s]));
        if (cat_care[s])
            check("cathodes", 32'(cathodes), 32'(exp_cat[s]));
        check("dp_n", 32'(dp_n), 32'(exp_dpn[s]));
        check("frame_done", 32'(frame_done), 32'(cyc % 16 == 0));
    endtask

    task automatic run_to(input int t);
        while (cyc < t) begin
            tick();
            check_cycle();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk,
                           input logic lz, input logic [3:0] br);
        digit_data = d;
        dp         = dpv;
        blank      = blk;
        lzs_en     = lz;
        brightness = br;
        load       = 1'b1;
        tick();
        check_cycle();
        load       = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        digit_data = '0;
        dp         = '0;
        blank      = '0;
        lzs_en     = 1'b0;
        brightness = '0;
        load       = 1'b0;
        cat_care   = '{1'b1, 1'b1, 1'b1, 1'b1};

        // Reset held, then released with nothing loaded: dark zeros
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        reset = 1'b0;
        cyc   = 0;
        check_reset_outputs("rst_release");
        exp_an  = '{4'hF, 4'hF, 4'hF, 4'hF};
        exp_cat = '{7'h01, 7'h01, 7'h01, 7'h01};
        exp_dpn = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_to(5);

        // Scan: 1234 at full brightness, visible from the first boundary
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'hF);
        run_to(16);
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_cat = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        run_to(37);

        // Tear: mid-frame load keeps old data until the next boundary
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0, 4'hF);
        run_to(48);
        exp_cat = '{7'h00, 7'h0F, 7'h20, 7'h24};
        run_to(64);

        // Leading-zero suppression on 0040
        do_load(16'h0040, 4'b0000, 4'b0000, 1'b1, 4'hF);
        run_to(80);
        exp_cat = '{7'h01, 7'h4C, 7'h7F, 7'h7F};
        run_to(96);

        // Blank slot 2, decimal point on digit 0
        do_load(16'h1234, 4'b0001, 4'b0100, 1'b0, 4'hF);
        run_to(112);
        exp_an   = '{4'hE, 4'hD, 4'hF, 4'h7};
        exp_cat  = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        exp_dpn  = '{1'b0, 1'b1, 1'b1, 1'b1};
        cat_care = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_to(128);

        // PWM duty 4/16: anode low only while pwm_cnt < 4, which lines up with slot 0
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'h4);
        run_to(144);
        exp_an   = '{4'hE, 4'hF, 4'hF, 4'hF};
        exp_dpn  = '{1'b1, 1'b1, 1'b1, 1'b1};
        cat_care = '{1'b1, 1'b1, 1'b1, 1'b1};
        low_cnt  = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_cycle();
            if (anodes != 4'hF)
                low_cnt++;
        end
        check("pwm_low_count", 32'(low_cnt), 32'd4);
        run_to(166);

        // Reset mid-slot with a load pending: discarded, outputs reset asynchronously
        do_load(16'hFFFF, 4'b1111, 4'b0000, 1'b0, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        check_reset_outputs("rst_mid_release");
        exp_an  = '{4'hF, 4'hF, 4'hF, 4'hF};
        exp_cat = '{7'h01, 7'h01, 7'h01, 7'h01};
        exp_dpn = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_to(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
